calc1_port_driver: RTL
======================

CALC1_PORT_DRIVER -- requirements
Module: calc1_port_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, max WAIT-state cycles before a timeout result.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, request buffer entries (power of two, >=2).
REQ-003 SHALL have port c_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 SHALL have port req_cmd  input  [0:3]  calc1 command (1 add, 2 sub, 5 shl, 6 shr; others passed through).
REQ-008 SHALL have port req_op1  input  [0:31]  operand 1.
REQ-009 SHALL have port req_op2  input  [0:31]  operand 2.
REQ-010 SHALL have port port_cmd_out  output  [0:3]  to calc1 reqN_cmd_in.
REQ-011 SHALL have port port_data_out  output  [0:31]  to calc1 reqN_data_in.
REQ-012 SHALL have port port_resp_in  input  [0:1]  from calc1 out_respN.
REQ-013 SHALL have port port_data_in  input  [0:31]  from calc1 out_dataN.
REQ-014 SHALL have port rsp_valid  output  1  result available.
REQ-015 SHALL have port rsp_ready  input  1  result consumed when rsp_valid & rsp_ready.
REQ-016 SHALL have port rsp_code  output  [0:1]  1 success, 2 calc1 error, 3 timeout.
REQ-017 SHALL have port rsp_data  output  [0:31]  result data.
REQ-018 SHALL have port err_spurious  output  1  sticky: nonzero port_resp_in seen outside WAIT.

Function
REQ-019 SHALL buffer accepted requests in a FIFO_DEPTH-entry FIFO; req_ready = FIFO not full.
REQ-020 SHALL accept and discard requests with req_cmd=0 (never enqueued, req_ready unaffected).
REQ-021 SHALL allow enqueue and dequeue in the same cycle, including when full (occupancy unchanged).
REQ-022 SHALL implement FSM states IDLE, SEND1, SEND2, WAIT, HOLD.
REQ-023 IDLE -> SEND1 when FIFO non-empty; head entry popped on that transition.
REQ-024 SEND1 (1 cycle): port_cmd_out=cmd, port_data_out=op1; -> SEND2.
REQ-025 SEND2 (1 cycle): port_cmd_out=0, port_data_out=op2; -> WAIT, timeout counter cleared.
REQ-026 In IDLE, WAIT, HOLD port_cmd_out and port_data_out SHALL be 0.
REQ-027 WAIT: port_resp_in!=0 -> capture rsp_code=port_resp_in, rsp_data=port_data_in, -> HOLD next cycle.
REQ-028 WAIT: counter reaching TIMEOUT_CYCLES with port_resp_in=0 -> rsp_code=3, rsp_data=0, -> HOLD; counter width clog2(TIMEOUT_CYCLES+1).
REQ-029 Response and timeout in the same cycle: response wins.
REQ-030 HOLD: rsp_valid=1, rsp_code/rsp_data stable until rsp_ready; on handshake -> IDLE, or directly -> SEND1 if FIFO non-empty (pop same cycle).
REQ-031 Minimum issue-to-result latency SHALL be 3 cycles plus calc1 response latency; at most one operation outstanding.
REQ-032 port_resp_in!=0 in IDLE, SEND1, SEND2 or HOLD SHALL be ignored and set err_spurious (cleared only by reset).

Reset
REQ-033 Asserting reset SHALL immediately force: FSM=IDLE, FIFO empty, counter=0, req_ready=0 during reset, rsp_valid=0, rsp_code=0, rsp_data=0, port_cmd_out=0, port_data_out=0, err_spurious=0.
REQ-034 req_ready SHALL be 1 from the first clock edge after reset deassertion.
REQ-035 Reset mid-operation (any state) SHALL drop the in-flight operation and all queued requests with no result produced.

Structure
REQ-036 Shared package calc1_pkg SHALL hold command codes (CMD_NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), response codes (RESP_NONE=0, OK=1, ERR=2, TIMEOUT=3), and the FSM state typedef.
REQ-037 Request FIFO SHALL be sub-module calc1_req_fifo; FSM and counter live in calc1_port_driver.
REQ-038 Four instances, one per calc1 port, SHALL be usable without modification.

Verification
REQ-039 Add 0x00000001 + 0x1FFFFFFF against calc1 -> rsp_code=1, rsp_data=0x20000000; port_cmd_out=1 then 0 on consecutive cycles.
REQ-040 Add 0xFFFFFFFF + 0x00000001 -> rsp_code=2; sub 0x1 - 0xF -> rsp_code=2.
REQ-041 Silent port stub (port_resp_in tied 0), cmd=1 -> rsp_code=3, rsp_data=0 exactly 64 cycles after entering WAIT.
REQ-042 rsp_ready held 0, three requests issued -> first in HOLD, two queued, req_ready=0; release rsp_ready -> results in issue order, back-to-back via HOLD->SEND1.
REQ-043 Reset asserted during WAIT with one queued request -> all outputs 0 asynchronously, no rsp_valid after release, late port_resp_in ignored (err_spurious=1).
REQ-044 req_cmd=0 with req_valid=1 -> accepted, no port activity, no result.

Source files
------------

// File: rtl/calc1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc1_pkg
// Description : Shared command/response codes, request record and FSM state
//               type for the calc1 port driver.
// Revision    : 1.0 - initial release
// ============================================================================
package calc1_pkg;

   // calc1 command codes
   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   // calc1 / driver response codes
   localparam logic [1:0] RESP_NONE    = 2'd0;
   localparam logic [1:0] RESP_OK      = 2'd1;
   localparam logic [1:0] RESP_ERR     = 2'd2;
   localparam logic [1:0] RESP_TIMEOUT = 2'd3;

   // One queued request
   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] op1;
      logic [31:0] op2;
   } req_t;

   // Driver sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEND1 = 3'd1,
      ST_SEND2 = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4
   } state_e;

endpackage : calc1_pkg
`default_nettype wire

// File: rtl/calc1_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : calc1_req_fifo
// Description : Small synchronous request FIFO. Power-of-two depth, so the
//               pointers wrap naturally. Push while full is honoured only when
//               a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_req_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 68
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   // Qualify push/pop and compute next pointer and occupancy values
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule : calc1_req_fifo
`default_nettype wire

// File: rtl/calc1_port_driver.sv
`default_nettype none
// ============================================================================
// Module      : calc1_port_driver
// Description : Drives one calc1 request port. Buffers requests, issues each
//               as a two-cycle cmd/op1 then op2 sequence, waits for the
//               response (or times out) and holds the result until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_port_driver
   import calc1_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [0:3]  req_cmd,
   input  logic [0:31] req_op1,
   input  logic [0:31] req_op2,
   output logic [0:3]  port_cmd_out,
   output logic [0:31] port_data_out,
   input  logic [0:1]  port_resp_in,
   input  logic [0:31] port_data_in,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [0:1]  rsp_code,
   output logic [0:31] rsp_data,
   output logic        err_spurious
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int REQ_W = $bits(req_t);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       op2_q, op2_d;
   logic [3:0]        port_cmd_q, port_cmd_d;
   logic [31:0]       port_data_q, port_data_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [1:0]        rsp_code_q, rsp_code_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              err_spurious_q, err_spurious_d;
   logic              ready_en_q;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic              start_op;
   logic [REQ_W-1:0]  fifo_rd_data;
   req_t              head;

   // Held low through reset, then high from the first edge after release
   assign req_ready = ready_en_q & ~fifo_full;
   // NOP requests are handshaken but never stored
   assign fifo_push = req_valid & req_ready & (req_cmd != CMD_NOP);
   assign head      = req_t'(fifo_rd_data);

   calc1_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_req_fifo (
      .clk       (c_clk),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data ({req_cmd, req_op1, req_op2}),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Next-state, timeout counter and registered-output computation
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op2_d          = op2_q;
      port_cmd_d     = '0;
      port_data_d    = '0;
      rsp_valid_d    = rsp_valid_q;
      rsp_code_d     = rsp_code_q;
      rsp_data_d     = rsp_data_q;
      fifo_pop       = 1'b0;
      start_op       = 1'b0;
      err_spurious_d = err_spurious_q |
                       ((port_resp_in != RESP_NONE) && (state_q != ST_WAIT));

      case (state_q)
         ST_IDLE: begin
            start_op = ~fifo_empty;
         end
         ST_SEND1: begin
            state_d     = ST_SEND2;
            port_data_d = op2_q;
         end
         ST_SEND2: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A response arriving on the final count still wins over timeout
            if (port_resp_in != RESP_NONE) begin
               state_d     = ST_HOLD;
               rsp_valid_d = 1'b1;
               rsp_code_d  = port_resp_in;
               rsp_data_d  = port_data_in;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_d     = ST_HOLD;
                  rsp_valid_d = 1'b1;
                  rsp_code_d  = RESP_TIMEOUT;
                  rsp_data_d  = '0;
               end
            end
         end
         ST_HOLD: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_code_d  = RESP_NONE;
               rsp_data_d  = '0;
               start_op    = ~fifo_empty;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Launch the head request: SEND1 drives cmd/op1, op2 is kept for SEND2
      if (start_op) begin
         fifo_pop    = 1'b1;
         state_d     = ST_SEND1;
         port_cmd_d  = head.cmd;
         port_data_d = head.op1;
         op2_d       = head.op2;
      end
   end

   // State and output registers; reset abandons any in-flight operation
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         op2_q          <= '0;
         port_cmd_q     <= '0;
         port_data_q    <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_code_q     <= '0;
         rsp_data_q     <= '0;
         err_spurious_q <= 1'b0;
         ready_en_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         op2_q          <= op2_d;
         port_cmd_q     <= port_cmd_d;
         port_data_q    <= port_data_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_code_q     <= rsp_code_d;
         rsp_data_q     <= rsp_data_d;
         err_spurious_q <= err_spurious_d;
         ready_en_q     <= 1'b1;
      end
   end

   assign port_cmd_out  = port_cmd_q;
   assign port_data_out = port_data_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_code      = rsp_code_q;
   assign rsp_data      = rsp_data_q;
   assign err_spurious  = err_spurious_q;

endmodule : calc1_port_driver
`default_nettype wire
